fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of Instruction_Memory.
- Owns the program counter and drives the byte address into the instruction memory, which returns a 32-bit big-endian-assembled word combinationally in the same cycle.
- Registers that word with its PC into an IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, halt on EBREAK/ECALL, and address-range checking.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 1024, instruction memory size in bytes; a legal PC satisfies PC <= IMEM_BYTES-4.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low; one clock, sampled on rising edge of clk.
stall_i  in  1  downstream hazard stall; holds PC and IF/ID.
redir_valid_i  in  1  taken branch/jump from execute.
redir_target_i  in  32  redirect byte address.
im_inst_i  in  32  instruction word returned by instruction memory for im_addr_o.
im_addr_o  out  32  fetch address to instruction memory (equals PC register).
ifid_valid_o  out  1  IF/ID register holds a real instruction.
ifid_pc_o  out  32  PC of the registered instruction.
ifid_pc4_o  out  32  ifid_pc_o + 4.
ifid_inst_o  out  32  registered instruction word.
halted_o  out  1  fetch stopped (HALT state).
fetch_err_o  out  1  sticky: PC left legal range (or misaligned target, see option).

Behaviour:
- Reset (rst_n low at edge): PC=RESET_VECTOR, state=BOOT, ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_inst_o=32'h0000_0013 (NOP), halted_o=0, fetch_err_o=0. Reset overrides everything, including mid-redirect or HALT.
- States: BOOT -> RUN unconditionally after one cycle. BOOT issues no valid instruction; the PC is presented but not captured. RUN -> HALT on halt condition. HALT exits only via reset.
- RUN, per edge, priority redirect > stall > advance:
  - Redirect: PC=redir_target_i; IF/ID flushed (valid=0, inst=NOP). Applies even when stall_i=1.
  - Stall: PC and all IF/ID fields hold.
  - Advance: IF/ID={1, PC, PC+4, im_inst_i}; PC=PC+4 (32-bit wrap, no carry out).
- Range check, combinational on PC in RUN: if PC > IMEM_BYTES-4, then next edge sets fetch_err_o=1 and enters HALT. The instruction is not captured and IF/ID is flushed.
- Halt condition: advancing with im_inst_i == 32'h0010_0073 (EBREAK) or 32'h0000_0073 (ECALL).
  - That instruction IS captured (valid=1) that cycle.
  - Next state is HALT; PC holds at its address.
- HALT: PC frozen, halted_o=1. IF/ID holds its last content for one cycle, then ifid_valid_o=0 from the following edge onward. stall_i and redir_valid_i are ignored.
- Latency: instruction visible on ifid_* one cycle after its address appears on im_addr_o. After a redirect, the first valid target instruction appears 2 edges later (one bubble).
- Simultaneous redirect and halt-instruction fetch: redirect wins and the halt instruction is discarded.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect with redir_target_i[1:0] != 0 sets fetch_err_o=1, flushes IF/ID, loads no PC, and enters HALT.
- Undefined: target[1:0] is forced to 2'b00 before loading the PC; no error is raised.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {BOOT, RUN, HALT}; constants NOP_INST=32'h0000_0013, EBREAK_INST, ECALL_INST; typedef ifid_t struct {valid, pc, pc4, inst}.
- One natural sub-module: ifid_reg (IF/ID pipeline register with hold/flush/load controls, synchronous active-low reset). fetch_unit contains the PC, FSM and next-PC mux.

Test Plan:
- Reset then free-run, memory holding ADDI words at 0,4,8: im_addr_o steps 0,0,4,8. ifid_valid_o is first high on the 2nd post-reset edge with ifid_pc_o=0, ifid_pc4_o=4.
- stall_i high for 3 cycles at PC=8: im_addr_o stays 8 and ifid_* unchanged for 3 edges; advance resumes to 12.
- redir_valid_i with target 32'h40 while stall_i=1: next edge im_addr_o=0x40, ifid_valid_o=0; the edge after that gives ifid_pc_o=0x40.
- EBREAK at 0x10: it is captured with valid=1 and pc=0x10; halted_o=1; PC held at 0x10; valid=0 one edge later. A redirect to 0 during HALT is ignored.
- Run to PC=0x3FC then 0x400 (IMEM_BYTES=1024): word at 0x3FC is captured; at 0x400 fetch_err_o=1, halted_o=1, ifid_valid_o=0.
- Redirect target 0x42: with MISALIGN_TRAP_EN, fetch_err_o=1 and HALT; without it, PC=0x40 and no error. rst_n low afterwards clears both to 0 and PC=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ifid_t;

  function automatic logic is_halt_inst(input logic [31:0] inst);
    return (inst == EBREAK_INST) || (inst == ECALL_INST);
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats load, neither means hold.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o
);

  ifid_t ifid_q, ifid_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else if (load_i) begin
      ifid_d.valid = 1'b1;
      ifid_d.pc    = pc_i;
      ifid_d.pc4   = pc4_i;
      ifid_d.inst  = inst_i;
    end
  end

  // NOTE: state registers use non-blocking assignment; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_q.valid <= 1'b0;
      ifid_q.pc    <= 32'h0;
      ifid_q.pc4   <= 32'h0;
      ifid_q.inst  <= NOP_INST;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign valid_o = ifid_q.valid;
  assign pc_o    = ifid_q.pc;
  assign pc4_o   = ifid_q.pc4;
  assign inst_o  = ifid_q.inst;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, BOOT/RUN/HALT control, next-PC mux, range check.
// Define MISALIGN_TRAP_EN to trap on redirect targets that are not word aligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_target_i,
  input  logic [31:0] im_inst_i,
  output logic [31:0] im_addr_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_inst_o,
  output logic        halted_o,
  output logic        fetch_err_o
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic         ifid_load, ifid_flush;
  logic [31:0]  pc_plus4;
  logic         pc_illegal;

  assign pc_plus4   = pc_q + 32'd4;
  assign pc_illegal = pc_q > LAST_PC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;

    unique case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (redir_valid_i) begin
          ifid_flush = 1'b1;
`ifdef MISALIGN_TRAP_EN
          if (redir_target_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = redir_target_i;
          end
`else
          pc_d = redir_target_i & 32'hFFFF_FFFC;
`endif
        end else if (pc_illegal) begin
          // The out-of-range word is never captured; fetch stops here.
          ifid_flush = 1'b1;
          err_d      = 1'b1;
          state_d    = HALT;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          if (is_halt_inst(im_inst_i)) begin
            state_d = HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      HALT: ifid_flush = 1'b1;

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .inst_i  (im_inst_i),
    .valid_o (ifid_valid_o),
    .pc_o    (ifid_pc_o),
    .pc4_o   (ifid_pc4_o),
    .inst_o  (ifid_inst_o)
  );

  assign im_addr_o   = pc_q;
  assign halted_o    = (state_q == HALT);
  assign fetch_err_o = err_q;

endmodule
